// File: rtl/nlz_norm_pipe.sv
// nlz_norm_pipe
//   Two-stage leading-zero counter and normalizer for 32-bit operands with a
//   valid/ready handshake on both sides and a sideband tag carried alongside.
//
//   Stage 1 captures, per nibble, a zero flag and a 2-bit local leading-zero
//   count, together with the operand and its tag. Stage 2 picks the first
//   non-zero nibble from the MSB, forms the full count, and shifts the operand
//   left by that count.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_flush  : synchronous flush, drops everything in flight
//   i_valid  : operand valid          o_ready : operand can be accepted
//   i_data   : 32-bit operand         i_tag   : sideband tag
//   o_valid  : result valid           i_ready : downstream accepts result
//   o_nlz    : leading-zero count 0..32
//   o_norm   : operand shifted left by o_nlz
//   o_zero   : operand was all zeros
//   o_tag    : tag captured with the operand
module nlz_norm_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_data,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [5:0]       o_nlz,
  output logic [31:0]      o_norm,
  output logic             o_zero,
  output logic [TAG_W-1:0] o_tag
);

  // Local leading-zero count of one nibble. An all-zero nibble is flagged
  // separately, so its count here is never used.
  function automatic logic [1:0] lzc4(input logic [3:0] nib);
    logic [1:0] c;
    if (nib[3])      c = 2'd0;
    else if (nib[2]) c = 2'd1;
    else if (nib[1]) c = 2'd2;
    else             c = 2'd3;
    return c;
  endfunction

  // Stage-1 registers
  logic             vld_p1_q;
  logic [7:0]       zf_p1_q,   zf_p1_d;
  logic [15:0]      lc_p1_q,   lc_p1_d;
  logic [31:0]      data_p1_q;
  logic [TAG_W-1:0] tag_p1_q;

  // Stage-2 registers
  logic             vld_p2_q;
  logic [5:0]       nlz_p2_q,  nlz_p2_d;
  logic [31:0]      norm_p2_q, norm_p2_d;
  logic             zero_p2_q, zero_p2_d;
  logic [TAG_W-1:0] tag_p2_q;

  logic adv_p1, adv_p2, load_p1, load_p2;

  assign adv_p2  = !vld_p2_q || i_ready;
  assign adv_p1  = !vld_p1_q || adv_p2;
  assign o_ready = adv_p1 && !i_flush;
  assign load_p1 = o_ready && i_valid;
  assign load_p2 = adv_p2 && vld_p1_q && !i_flush;

  // ---- Stage 0 -> 1: per-nibble zero flags and local counts ----
  // Nibble index 0 is bits 31:28, index 7 is bits 3:0.
  always_comb begin
    zf_p1_d = '0;
    lc_p1_d = '0;
    for (int i = 0; i < 8; i++) begin
      zf_p1_d[i]       = (i_data[31-4*i -: 4] == 4'd0);
      lc_p1_d[2*i +: 2] = lzc4(i_data[31-4*i -: 4]);
    end
  end

  // ---- Stage 1 -> 2: combine counts and shift ----
  always_comb begin
    logic found;
    found    = 1'b0;
    nlz_p2_d = 6'd32;
    for (int i = 0; i < 8; i++) begin
      if (!found && !zf_p1_q[i]) begin
        found    = 1'b1;
        nlz_p2_d = {1'b0, 3'(i), lc_p1_q[2*i +: 2]};
      end
    end
    zero_p2_d = &zf_p1_q;
    // A non-zero operand always has nlz < 32, so five shift bits suffice.
    norm_p2_d = zero_p2_d ? 32'd0 : (data_p1_q << nlz_p2_d[4:0]);
  end

  // Valid flags. Flush wins over advance; an output transfer in the same
  // cycle as a flush still completes because the downstream sees o_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (i_flush) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (adv_p1) vld_p1_q <= i_valid;
      if (adv_p2) vld_p2_q <= vld_p1_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      zf_p1_q   <= '0;
      lc_p1_q   <= '0;
      data_p1_q <= '0;
      tag_p1_q  <= '0;
    end else if (load_p1) begin
      zf_p1_q   <= zf_p1_d;
      lc_p1_q   <= lc_p1_d;
      data_p1_q <= i_data;
      tag_p1_q  <= i_tag;
    end
  end

  // Output registers only load with a real operand, so a stalled or
  // draining stage 2 keeps its outputs unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      nlz_p2_q  <= '0;
      norm_p2_q <= '0;
      zero_p2_q <= 1'b0;
      tag_p2_q  <= '0;
    end else if (load_p2) begin
      nlz_p2_q  <= nlz_p2_d;
      norm_p2_q <= norm_p2_d;
      zero_p2_q <= zero_p2_d;
      tag_p2_q  <= tag_p1_q;
    end
  end

  assign o_valid = vld_p2_q;
  assign o_nlz   = nlz_p2_q;
  assign o_norm  = norm_p2_q;
  assign o_zero  = zero_p2_q;
  assign o_tag   = tag_p2_q;

endmodule

// File: tb/tb_nlz_norm_pipe.sv
module tb_nlz_norm_pipe;
  localparam int TAG_W = 4;

  logic             clk, rst_n, flush, in_valid, out_ready;
  logic             in_ready, out_valid, out_zero;
  logic [31:0]      in_data, out_norm;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [5:0]       out_nlz;

  nlz_norm_pipe #(.TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_valid(in_valid), .o_ready(in_ready),
    .i_data(in_data), .i_tag(in_tag),
    .o_valid(out_valid), .i_ready(out_ready),
    .o_nlz(out_nlz), .o_norm(out_norm), .o_zero(out_zero), .o_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [5:0]       nlz;
    logic [31:0]      norm;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } res_t;

  // Reference: count zeros from the top bit down, then shift.
  function automatic res_t model(input logic [31:0] d, input logic [TAG_W-1:0] t);
    res_t r;
    int n = 0;
    while (n < 32 && d[31-n] == 1'b0) n++;
    r.nlz  = 6'(n);
    r.zero = (d == 32'd0);
    r.norm = (n == 32) ? 32'd0 : (d << n);
    r.tag  = t;
    return r;
  endfunction

  res_t exp_q[$];
  logic held = 1'b0;
  res_t held_v;

  // Scoreboard: results must come out in acceptance order, and a stalled
  // result must not change.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        chk("hold_nlz",  out_nlz,  held_v.nlz);
        chk("hold_norm", out_norm, held_v.norm);
        chk("hold_zero", out_zero, held_v.zero);
        chk("hold_tag",  out_tag,  held_v.tag);
      end
      held = out_valid && !out_ready;
      held_v.nlz = out_nlz; held_v.norm = out_norm;
      held_v.zero = out_zero; held_v.tag = out_tag;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_result", 1, 0);
        else begin
          res_t e;
          e = exp_q.pop_front();
          chk("nlz",  out_nlz,  e.nlz);
          chk("norm", out_norm, e.norm);
          chk("zero", out_zero, e.zero);
          chk("tag",  out_tag,  e.tag);
        end
      end
      if (flush) begin
        exp_q.delete();
        held = 1'b0;
      end else if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, in_tag));
      end
    end
  end

  // Present one operand and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d, input logic [TAG_W-1:0] t);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_tag = t;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin chk("send_timeout", 0, 1); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 || out_valid) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin chk("drain_timeout", 0, 1); break; end
    end
  endtask

  task automatic idle_no_valid(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("no_stale_valid", out_valid, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_tag = '0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_nlz",   out_nlz,   0);
    chk("rst_norm",  out_norm,  0);
    chk("rst_zero",  out_zero,  0);
    chk("rst_tag",   out_tag,   0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", in_ready, 1);

    // Single operand latency.
    in_valid = 1'b1; in_data = 32'h0001_0000; in_tag = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_not_yet", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid", out_valid, 1);
    chk("lat_nlz",   out_nlz,   15);
    chk("lat_norm",  out_norm,  32'h8000_0000);
    chk("lat_zero",  out_zero,  0);
    chk("lat_tag",   out_tag,   3);
    drain();

    // Extremes.
    send(32'h0, 4'd5);
    send(32'hFFFF_FFFF, 4'd6);
    send(32'h0000_0001, 4'd7);
    drain();

    // Back-to-back walking one: result c-2 appears in cycle c.
    for (int c = 0; c < 11; c++) begin
      in_valid = (c < 8);
      in_data  = 32'h8000_0000 >> c;
      in_tag   = 4'(c);
      @(negedge clk);
      if (c >= 2 && c <= 9) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_nlz",   out_nlz,   c - 2);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: two accepted, third blocked for four cycles.
    out_ready = 1'b0;
    send(32'h0000_0F00, 4'd1);
    send(32'h00F0_0000, 4'd2);
    in_valid = 1'b1; in_data = 32'h0000_0003; in_tag = 4'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h0000_0003, 4'd4);
    drain();

    // Flush with both stages full.
    out_ready = 1'b0;
    send(32'h1234_5678, 4'd8);
    send(32'h0000_5678, 4'd9);
    flush = 1'b1;
    in_valid = 1'b1; in_data = 32'h1; in_tag = 4'd10;
    @(negedge clk);
    chk("flush_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    out_ready = 1'b1;
    idle_no_valid(5);

    // Flush coinciding with an output transfer.
    out_ready = 1'b0;
    send(32'h0400_0000, 4'd11);
    send(32'h0000_0040, 4'd12);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle_no_valid(5);

    // Reset with two in flight.
    send(32'h0080_0000, 4'd13);
    send(32'h0000_8000, 4'd14);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_nlz",   out_nlz,   0);
    chk("arst_norm",  out_norm,  0);
    chk("arst_zero",  out_zero,  0);
    chk("arst_tag",   out_tag,   0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle_no_valid(6);

    // Random traffic.
    begin
      int acc = 0;
      int cyc = 0;
      while (acc < 10000 && cyc < 60000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        in_data   = $urandom >> $urandom_range(0, 32);
        in_tag    = 4'($urandom);
        @(negedge clk);
        if (in_valid && in_ready) acc++;
        @(posedge clk); #1;
        cyc++;
      end
      in_valid = 1'b0;
      chk("rand_accepted", acc, 10000);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nlz_norm_pipe.md
NLZ_NORM_PIPE -- requirements
Module: nlz_norm_pipe

Interface
REQ-001 Parameter TAG_W, default 4, width of the sideband tag carried with each operand.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_flush  input  1  synchronous pipeline flush.
REQ-005 i_valid  input  1  upstream operand valid.
REQ-006 o_ready  output  1  block can accept an operand this cycle.
REQ-007 i_data  input  32  operand to count and normalize.
REQ-008 i_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-009 o_valid  output  1  result valid.
REQ-010 i_ready  input  1  downstream accepts the result.
REQ-011 o_nlz  output  6  leading-zero count of the operand, range 0..32.
REQ-012 o_norm  output  32  operand shifted left by o_nlz, zeros shifted in.
REQ-013 o_zero  output  1  operand was all zeros.
REQ-014 o_tag  output  TAG_W  tag of the operand that produced the result.

Function
REQ-015 The datapath SHALL be a two-stage pipeline: S1 registers eight per-nibble zero flags, eight 2-bit local leading-zero counts, the operand and the tag; S2 registers the combined count, the shifted operand, o_zero and o_tag.
REQ-016 A transfer in SHALL occur on a cycle with i_valid=1 and o_ready=1; a transfer out SHALL occur on a cycle with o_valid=1 and i_ready=1.
REQ-017 S2 SHALL advance when it is empty or its result transfers out; S1 SHALL advance when it is empty or S2 advances; o_ready SHALL equal the S1 advance condition, combinationally.
REQ-018 Latency SHALL be 2 cycles from the input transfer to o_valid=1 with no stall, at a sustained throughput of one operand per cycle.
REQ-019 While o_valid=1 and i_ready=0, all outputs SHALL hold stable.
REQ-020 Combine rule: the first nibble from the MSB whose zero flag is clear is index k (0 = bits 31:28); o_nlz SHALL equal 4*k plus that nibble's local count.
REQ-021 When all eight nibble flags are set: o_nlz SHALL be 32, o_zero SHALL be 1 and o_norm SHALL be 0.
REQ-022 For nonzero operands, o_zero SHALL be 0, o_norm[31] SHALL be 1, and the shift SHALL be logical with no wrap-around.
REQ-023 o_tag SHALL be the i_tag captured with the same operand; ordering SHALL be strictly FIFO and no operand SHALL be dropped or duplicated.
REQ-024 i_flush=1 SHALL clear both stage-valid flags at the next edge, and no operand SHALL be accepted on a flush cycle; o_ready SHALL be 0 while i_flush=1.
REQ-025 When a flush coincides with an output transfer, the transfer SHALL complete and no further result SHALL appear.
REQ-026 When S2 is full and stalled, a new operand SHALL be accepted into S1 only if S1 is empty; otherwise o_ready=0.

Reset
REQ-027 On i_rst_n=0, asynchronously: both valid flags SHALL clear, o_valid=0, o_nlz=0, o_norm=0, o_zero=0 and o_tag=0; o_ready SHALL be 1 once i_rst_n=1.
REQ-028 A reset asserted mid-operation SHALL discard all in-flight operands, and no result SHALL emerge after release.

Verification
REQ-029 i_data=32'h0001_0000, tag 3, i_ready=1 -> two cycles later o_valid=1, o_nlz=15, o_norm=32'h8000_0000, o_zero=0, o_tag=3.
REQ-030 i_data=0 -> o_nlz=32, o_zero=1, o_norm=0; i_data=32'hFFFF_FFFF -> o_nlz=0, o_norm=32'hFFFF_FFFF.
REQ-031 Back-to-back 8 operands 32'h8000_0000>>n (n=0..7), i_ready=1 -> eight consecutive valid results, o_nlz=0..7 in order.
REQ-032 Stream of 3 operands with i_ready=0 for 4 cycles -> o_ready drops after 2 accepted, outputs hold stable, and all 3 results emerge in order after i_ready=1.
REQ-033 Flush with both stages full -> o_valid=0 the next cycle and no stale result appears; reset asserted with 2 in flight -> all outputs 0 asynchronously, no result after release.
REQ-034 Random 10k operands with random i_valid/i_ready -> every result matches the reference count/shift model, tags in order.
